ga_mv_regfile: RTL and testbench

- Multi-port register file holding geometric-algebra multivectors for the GA coprocessor.
- Two combinational read ports feed the GA ALU operands; one synchronous write port takes the ALU result.
- A 32-bit debug word port gives the host read/write access to individual multivector words.

---
 rtl/ga_pkg.sv | 7 +
 rtl/ga_rf_read_mux.sv | 27 ++
 rtl/ga_mv_regfile.sv | 68 ++++++
 tb/tb_ga_mv_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared GA coprocessor types and constants
package ga_pkg;
    localparam int GA_REG_ADDR_WIDTH = 5;
    localparam int GA_MV_WORDS = 8;
    localparam int GA_WORD_WIDTH = 32;
    typedef logic [GA_MV_WORDS-1:0][GA_WORD_WIDTH-1:0] ga_multivector_t;
endpackage

// File: rtl/ga_rf_read_mux.sv
// ga_rf_read_mux: range-checked register select with write-through forwarding when GA_RF_BYPASS_EN is defined
module ga_rf_read_mux
    import ga_pkg::*;
#(
    parameter int NumRegs = 2 ** GA_REG_ADDR_WIDTH,
    parameter int DataWidth = $bits(ga_multivector_t),
    parameter int AddrWidth = $clog2(NumRegs)
) (
    input  logic [NumRegs-1:0][DataWidth-1:0] regs,
    input  logic [AddrWidth-1:0]              raddr,
    input  logic                              fwd_en,
    input  logic [AddrWidth-1:0]              waddr,
    input  logic [DataWidth-1:0]              wdata,
    output logic [DataWidth-1:0]              rdata
);
    logic in_range;
    logic hit;
    assign in_range = 32'(raddr) < NumRegs;
`ifdef GA_RF_BYPASS_EN
    assign hit = fwd_en && (waddr == raddr);
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, waddr, wdata};
    assign hit = 1'b0;
`endif
    assign rdata = !in_range ? '0 : hit ? wdata : regs[raddr];
endmodule

// File: rtl/ga_mv_regfile.sv
// ga_mv_regfile: multivector register file, two read ports, one write port, 32-bit debug word port
// Optional write-through forwarding is enabled by defining GA_RF_BYPASS_EN.
module ga_mv_regfile
    import ga_pkg::*;
#(
    parameter int NumRegs = 2 ** GA_REG_ADDR_WIDTH,
    parameter int DataWidth = $bits(ga_multivector_t),
    parameter int AddrWidth = $clog2(NumRegs),
    parameter int WordSelWidth = (DataWidth / GA_WORD_WIDTH > 1) ? $clog2(DataWidth / GA_WORD_WIDTH) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              we_i,
    input  logic [AddrWidth-1:0]              waddr_i,
    input  logic [DataWidth-1:0]              wdata_i,
    input  logic [AddrWidth-1:0]              raddr_a_i,
    input  logic [AddrWidth-1:0]              raddr_b_i,
    output logic [DataWidth-1:0]              rdata_a_o,
    output logic [DataWidth-1:0]              rdata_b_o,
    input  logic                              dbg_we_i,
    input  logic [AddrWidth+WordSelWidth-1:0] dbg_addr_i,
    input  logic [GA_WORD_WIDTH-1:0]          dbg_wdata_i,
    output logic [GA_WORD_WIDTH-1:0]          dbg_rdata_o
);
    localparam int NumWords = DataWidth / GA_WORD_WIDTH;

    logic [NumRegs-1:0][DataWidth-1:0] regs;
    logic [AddrWidth-1:0]              dbg_idx;
    logic [WordSelWidth-1:0]           dbg_sel;
    logic                              dbg_sel_ok;
    logic                              fwd_en;
    logic [DataWidth-1:0]              dbg_row;

    assign dbg_idx = dbg_addr_i[WordSelWidth +: AddrWidth];
    assign dbg_sel = dbg_addr_i[WordSelWidth-1:0];
    assign dbg_sel_ok = 32'(dbg_sel) < NumWords;
    // Reads must show zero while reset is held, so forwarding is suppressed then too.
    assign fwd_en = we_i && !rst_i;

    // Register array: main write takes the whole register and beats a debug word write to the same index;
    // out-of-range indices never match a register so those writes fall away.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                if (we_i && waddr_i == AddrWidth'(r))
                    regs[r] <= wdata_i;
                else if (dbg_we_i && dbg_sel_ok && dbg_idx == AddrWidth'(r))
                    regs[r][GA_WORD_WIDTH*dbg_sel +: GA_WORD_WIDTH] <= dbg_wdata_i;
            end
        end
    end

    ga_rf_read_mux #(.NumRegs(NumRegs), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_mux_a (
        .regs(regs), .raddr(raddr_a_i), .fwd_en(fwd_en), .waddr(waddr_i), .wdata(wdata_i), .rdata(rdata_a_o)
    );

    ga_rf_read_mux #(.NumRegs(NumRegs), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_mux_b (
        .regs(regs), .raddr(raddr_b_i), .fwd_en(fwd_en), .waddr(waddr_i), .wdata(wdata_i), .rdata(rdata_b_o)
    );

    ga_rf_read_mux #(.NumRegs(NumRegs), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_mux_dbg (
        .regs(regs), .raddr(dbg_idx), .fwd_en(fwd_en), .waddr(waddr_i), .wdata(wdata_i), .rdata(dbg_row)
    );

    assign dbg_rdata_o = dbg_sel_ok ? dbg_row[GA_WORD_WIDTH*dbg_sel +: GA_WORD_WIDTH] : '0;
endmodule

// File: tb/tb_ga_mv_regfile.sv
// tb_ga_mv_regfile: scoreboard bench for ga_mv_regfile with a non-power-of-two register count
module tb_ga_mv_regfile;
    localparam int NR = 20;
    localparam int DW = 256;
    localparam int AW = 5;
    localparam int WS = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          we_i = 1'b0;
    logic [AW-1:0] waddr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [AW-1:0] raddr_a_i = '0;
    logic [AW-1:0] raddr_b_i = '0;
    logic [DW-1:0] rdata_a_o;
    logic [DW-1:0] rdata_b_o;
    logic          dbg_we_i = 1'b0;
    logic [AW+WS-1:0] dbg_addr_i = '0;
    logic [31:0]   dbg_wdata_i = '0;
    logic [31:0]   dbg_rdata_o;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl[NR];
    int            vectors = 0;
    int            miscompares = 0;

    ga_mv_regfile #(.NumRegs(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
        .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (int'(a) >= NR) return '0;
`ifdef GA_RF_BYPASS_EN
        if (we_i && !rst_i && waddr_i == a) return wdata_i;
`endif
        return mdl[a];
    endfunction

    function automatic logic [DW-1:0] ref_dbg(input logic [AW+WS-1:0] d);
        logic [DW-1:0] row;
        logic [WS-1:0] s;
        row = ref_rd(d[AW+WS-1:WS]);
        s = d[WS-1:0];
        return {224'b0, row[32*s +: 32]};
    endfunction

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW+WS-1:0] d);
        exp_t e;
        raddr_a_i = a;
        raddr_b_i = b;
        dbg_addr_i = d;
        exp_q.push_back('{{tag, "_a"}, 0, ref_rd(a)});
        exp_q.push_back('{{tag, "_b"}, 1, ref_rd(b)});
        exp_q.push_back('{{tag, "_dbg"}, 2, ref_dbg(d)});
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, e.port == 0 ? rdata_a_o : e.port == 1 ? rdata_b_o : {224'b0, dbg_rdata_o}, e.exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] data);
        we_i = 1'b1;
        waddr_i = a;
        wdata_i = data;
    endtask

    task automatic dbgw(input logic [AW+WS-1:0] d, input logic [31:0] data);
        dbg_we_i = 1'b1;
        dbg_addr_i = d;
        dbg_wdata_i = data;
    endtask

    task automatic cycle();
        logic [DW-1:0] nxt[NR];
        logic [AW-1:0] di;
        logic [WS-1:0] ds;
        nxt = mdl;
        di = dbg_addr_i[AW+WS-1:WS];
        ds = dbg_addr_i[WS-1:0];
        if (dbg_we_i && int'(di) < NR) nxt[di][32*ds +: 32] = dbg_wdata_i;
        if (we_i && int'(waddr_i) < NR) nxt[waddr_i] = wdata_i;
        @(posedge clk_i);
        mdl = nxt;
        #1;
        we_i = 1'b0;
        dbg_we_i = 1'b0;
    endtask

    initial begin
        logic [AW-1:0]    ra;
        logic [AW-1:0]    rb;
        logic [AW+WS-1:0] rd_d;
        foreach (mdl[i]) mdl[i] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rd("rst_state", 0, 3, {5'd7, 3'd2});
        rst_i = 1'b0;
        wr(3, 256'h1234);
        cycle();
        rd("wr3", 3, 3, {5'd3, 3'd0});
        #2;
        rst_i = 1'b1;
        foreach (mdl[i]) mdl[i] = '0;
        rd("async_rst", 3, 3, {5'd3, 3'd0});
        wr(3, '1);
        rd("rst_hold_we", 3, 3, {5'd3, 3'd0});
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        we_i = 1'b0;
        rd("rst_wr_ign", 3, 3, {5'd3, 3'd0});
        wr(5, 256'hDEAD_BEEF);
        rd("lat_same", 5, 0, {5'd5, 3'd0});
        cycle();
        rd("lat_next", 5, 5, {5'd5, 3'd0});
        check("lat_const", rdata_a_o, 256'hDEAD_BEEF);
        wr(1, 256'hA);
        cycle();
        wr(2, 256'hB);
        cycle();
        rd("dual", 1, 2, {5'd2, 3'd0});
        check("dual_b_const", rdata_b_o, 256'hB);
        rd("dual_same", 2, 2, {5'd1, 3'd0});
        wr(7, {8{32'h0101_0101}});
        cycle();
        dbgw({5'd7, 3'd2}, 32'hCAFE_F00D);
        cycle();
        rd("dbg_wr", 7, 7, {5'd7, 3'd2});
        check("dbg_rd_const", {224'b0, dbg_rdata_o}, 256'hCAFE_F00D);
        check("dbg_row_const", rdata_a_o, {{5{32'h0101_0101}}, 32'hCAFE_F00D, {2{32'h0101_0101}}});
        rd("dbg_w1", 7, 7, {5'd7, 3'd1});
        wr(4, '1);
        dbgw({5'd4, 3'd0}, 32'h0);
        cycle();
        rd("coll_same", 4, 4, {5'd4, 3'd0});
        check("coll_const", rdata_a_o, {DW{1'b1}});
        wr(4, 256'h4444);
        dbgw({5'd6, 3'd3}, 32'h1234_5678);
        cycle();
        rd("coll_diff", 4, 6, {5'd6, 3'd3});
        check("coll_dbg_const", {224'b0, dbg_rdata_o}, 256'h1234_5678);
        wr(25, '1);
        dbgw({5'd25, 3'd0}, 32'hFFFF_FFFF);
        rd("oor_same", 25, 25, {5'd25, 3'd1});
        cycle();
        for (int i = 0; i < NR; i += 2) begin
            rd("oor_scan", AW'(i), AW'(i + 1), {AW'(i), 3'd0});
        end
        rd("oor_rd", 25, 24, {5'd25, 3'd0});
        check("oor_const", rdata_a_o, '0);
        for (int n = 0; n < 60; n++) begin
            we_i = 1'(($urandom_range(0, 1)));
            waddr_i = AW'($urandom_range(0, 23));
            for (int k = 0; k < 8; k++) wdata_i[32*k +: 32] = $urandom;
            dbg_we_i = 1'($urandom_range(0, 1));
            dbg_wdata_i = $urandom;
            ra = $urandom_range(0, 1) ? waddr_i : AW'($urandom_range(0, 23));
            rb = AW'($urandom_range(0, 23));
            rd_d = {($urandom_range(0, 2) == 0) ? waddr_i : AW'($urandom_range(0, 23)), WS'($urandom_range(0, 7))};
            rd("rand", ra, rb, rd_d);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
